// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// plus the mthi/mtlo/mfhi/mflo moves on the architectural HI/LO pair.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [WIDTH-1:0]   mcand;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: low half is dividend/quotient
  logic [WIDTH-1:0]   rem;

  logic               is_md;
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Request decode, operand magnitudes and one radix-2 step of either algorithm
  always_comb begin
    is_md     = (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU);
    is_signed = (funct == F_MULT) || (funct == F_DIV);
    mag_a     = (is_signed && op_a[WIDTH-1]) ? WIDTH'(-op_a) : op_a;
    mag_b     = (is_signed && op_b[WIDTH-1]) ? WIDTH'(-op_b) : op_b;

    mul_sum   = (WIDTH+1)'({1'b0, acc[2*WIDTH-1:WIDTH]}) +
                (acc[0] ? (WIDTH+1)'({1'b0, mcand}) : (WIDTH+1)'(0));

    // The shifted remainder is WIDTH+1 bits wide; its top bit is rem[WIDTH-1]
    div_shift = {rem[WIDTH-2:0], acc[WIDTH-1]};
    div_ge    = rem[WIDTH-1] || (div_shift >= mcand);
    div_sub   = div_shift - mcand;

    prod_fix  = (sign_a ^ sign_b) ? (2*WIDTH)'(-acc) : acc;
    quo_fix   = div_zero ? {WIDTH{1'b1}} :
                ((sign_a ^ sign_b) ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0]);
    rem_fix   = sign_a ? WIDTH'(-rem) : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (is_md) begin
              state    <= CALC;
              busy     <= 1'b1;
              cnt      <= '0;
              is_div   <= funct[1];
              sign_a   <= is_signed && op_a[WIDTH-1];
              sign_b   <= is_signed && op_b[WIDTH-1];
              div_zero <= (op_b == '0);
              mcand    <= funct[1] ? mag_b : mag_a;
              acc      <= {WIDTH'(0), (funct[1] ? mag_a : mag_b)};
              rem      <= '0;
            end else if (funct == F_MTHI) begin
              hi <= op_a;
            end else if (funct == F_MTLO) begin
              lo <= op_a;
            end
          end
        end

        CALC: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              rem <= div_ge ? div_sub : div_shift;
              acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH-1)) state <= FIX;
          end
        end

        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!abort) begin
            done <= 1'b1;
            if (is_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Move-from read port; the pipeline stalls on busy before using it
  always_comb begin
    case (funct)
      F_MFHI:  mf_data = hi;
      F_MFLO:  mf_data = lo;
      default: mf_data = '0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: arithmetic results, latency, busy/done
// handshake, moves, ignored starts, abort and asynchronous reset.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  localparam logic [5:0] F_NOP   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] mf_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct   (funct),
    .op_a    (op_a),
    .op_b    (op_b),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .mf_data (mf_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One-cycle start pulse; returns #1 after the start edge
  task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    funct = f;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct = F_NOP;
  endtask

  // Counts edges after the start edge until done is seen (bounded)
  task automatic wait_done(output int lat, output int busy_cyc, output bit held);
    logic [W-1:0] h0;
    logic [W-1:0] l0;
    h0       = hi;
    l0       = lo;
    lat      = 0;
    busy_cyc = busy ? 1 : 0;
    held     = 1'b1;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cyc++;
      if (!done && (hi !== h0 || lo !== l0)) held = 1'b0;
    end
  endtask

  task automatic do_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                       input logic [W-1:0] exp_lo);
    int lat;
    int bc;
    bit held;
    start_op(f, a, b);
    wait_done(lat, bc, held);
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int  lat;
    int  bc;
    bit  held;
    bit  saw_done;

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    funct = F_NOP;
    op_a  = '0;
    op_b  = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // multu 7*6 with full handshake checks
    start_op(F_MULTU, 32'd7, 32'd6);
    wait_done(lat, bc, held);
    check("multu_latency", 64'(lat), 64'd33);
    check("multu_busy_cycles", 64'(bc), 64'd33);
    check("multu_busy_after", 64'(busy), 64'd0);
    check("multu_no_partial", 64'(held), 64'd1);
    check("multu_hi", 64'(hi), 64'd0);
    check("multu_lo", 64'(lo), 64'h2A);
    @(posedge clk);
    #1;
    check("multu_done_pulse", 64'(done), 64'd0);

    do_md("mult_neg", F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    do_md("mult_minmin", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    do_md("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_md("divu_big", F_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF);
    do_md("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    do_md("divu_zero", F_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
    do_md("div_zero_neg", F_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    do_md("multu_wide", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // Back-to-back: start issued in the cycle done is visible
    start_op(F_MULTU, 32'd4, 32'd5);
    wait_done(lat, bc, held);
    check("b2b_lo_first", 64'(lo), 64'd20);
    do_md("b2b_second", F_MULTU, 32'd9, 32'd9, 32'd0, 32'd81);

    // Moves
    start_op(F_MTHI, 32'hAA, 32'h0);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    @(negedge clk);
    funct = F_MFHI;
    #1;
    check("mfhi_data", 64'(mf_data), 64'hAA);
    start_op(F_MTLO, 32'h55, 32'h0);
    check("mtlo_busy", 64'(busy), 64'd0);
    @(negedge clk);
    funct = F_MFLO;
    #1;
    check("mflo_data", 64'(mf_data), 64'h55);
    funct = F_NOP;

    // Start while busy is ignored
    start_op(F_MULTU, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    start_op(F_DIVU, 32'd100, 32'd7);
    wait_done(lat, bc, held);
    check("midstart_done", 64'(done), 64'd1);
    check("midstart_hi", 64'(hi), 64'd0);
    check("midstart_lo", 64'(lo), 64'd12);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midstart_no_second", 64'(saw_done), 64'd0);

    // Abort at CALC cycle 10
    start_op(F_MULTU, 32'h100, 32'h100);
    repeat (10) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd12);

    // Abort in IDLE drops a simultaneous start
    @(negedge clk);
    start = 1'b1;
    funct = F_MTHI;
    op_a  = 32'hDEAD;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    funct = F_NOP;
    check("idle_abort_busy", 64'(busy), 64'd0);
    check("idle_abort_hi", 64'(hi), 64'd0);

    // Asynchronous reset mid-CALC
    start_op(F_MTHI, 32'h77, 32'h0);
    start_op(F_MULTU, 32'd11, 32'd11);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_md("after_rst", F_MULTU, 32'd11, 32'd11, 32'd0, 32'd121);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
